// File: rtl/cache_flush_walker.sv
// Full-cache flush engine: walks every set/way, writes back dirty lines over a
// req/ack handshake and clears their dirty bits.
module cache_flush_walker #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FlushStart,
  input  logic               FlushAbort,
  input  logic               LineDirty,
  input  logic               WBAck,
  output logic [SETLEN-1:0]  FlushSet,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WBReq,
  output logic               ClearDirty,
  output logic               FlushBusy,
  output logic               FlushDone
);

  localparam int WAYW = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;
  localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);
  localparam logic [WAYW-1:0]   LAST_WAY = WAYW'(NUMWAYS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITEBACK,
    CLEAR,
    ADVANCE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SETLEN-1:0] set_q, set_d;
  logic [WAYW-1:0]   way_q, way_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
    end
  end

  // Abort has priority over everything except an in-flight writeback/clear.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    case (state_q)
      IDLE: begin
        if (FlushStart) begin
          state_d = READ;
          set_d   = '0;
          way_d   = '0;
        end
      end
      READ: begin
        state_d = FlushAbort ? DONE : CHECK;
      end
      CHECK: begin
        if (FlushAbort)     state_d = DONE;
        else if (LineDirty) state_d = WRITEBACK;
        else                state_d = ADVANCE;
      end
      WRITEBACK: begin
        if (WBAck) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = ADVANCE;
      end
      ADVANCE: begin
        if (FlushAbort || (set_q == LAST_SET && way_q == LAST_WAY)) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          if (way_q == LAST_WAY) begin
            way_d = '0;
            set_d = set_q + SETLEN'(1);
          end else begin
            way_d = way_q + WAYW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state register, so reset clears them
  // without waiting for a clock edge.
  always_comb begin
    FlushWay        = '0;
    FlushWay[way_q] = 1'b1;
  end

  assign FlushSet   = set_q;
  assign WBReq      = (state_q == WRITEBACK);
  assign ClearDirty = (state_q == CLEAR);
  assign FlushBusy  = (state_q != IDLE);
  assign FlushDone  = (state_q == DONE);

  a_way_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot(FlushWay));

  a_set_range: assert property (@(posedge clk) disable iff (!reset_n)
    set_q <= LAST_SET);

  a_wb_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (WBReq && !WBAck) |=> (WBReq && $stable(FlushSet) && $stable(FlushWay)));

  a_clear_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    ClearDirty |=> !ClearDirty);

  a_done_idle: assert property (@(posedge clk) disable iff (!reset_n)
    FlushDone |=> !FlushBusy);

endmodule

// File: tb/tb_cache_flush_walker.sv
// Bench for cache_flush_walker: a line-level flush model predicts every
// output cycle; a tag/dirty array and writeback responder drive the inputs.
module tb_cache_flush_walker;

  localparam int NUMWAYS  = 4;
  localparam int SETLEN   = 9;
  localparam int NUMLINES = 128;
  localparam int NOABORT  = 1 << 30;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               FlushStart, FlushAbort, LineDirty, WBAck;
  logic [SETLEN-1:0]  FlushSet;
  logic [NUMWAYS-1:0] FlushWay;
  logic               WBReq, ClearDirty, FlushBusy, FlushDone;

  always #5 clk = ~clk;

  cache_flush_walker #(.NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .NUMLINES(NUMLINES)) dut (
    .clk(clk), .reset_n(reset_n), .FlushStart(FlushStart), .FlushAbort(FlushAbort),
    .LineDirty(LineDirty), .WBAck(WBAck), .FlushSet(FlushSet), .FlushWay(FlushWay),
    .WBReq(WBReq), .ClearDirty(ClearDirty), .FlushBusy(FlushBusy), .FlushDone(FlushDone)
  );

  typedef struct packed {
    logic               busy;
    logic [SETLEN-1:0]  set;
    logic [NUMWAYS-1:0] way;
    logic               wbreq;
    logic               clr;
    logic               done;
  } obs_t;

  obs_t exp_q[$];
  bit   dirty [NUMLINES][NUMWAYS];
  bit   mem   [NUMLINES][NUMWAYS];
  int   lat   [NUMLINES][NUMWAYS];
  int   ackcnt;
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(input bit b, input int s, input int w,
                              input bit r, input bit c, input bit d);
    obs_t o;
    logic [NUMWAYS-1:0] one;
    one     = 1;
    o.busy  = b;
    o.set   = s[SETLEN-1:0];
    o.way   = one << w;
    o.wbreq = r;
    o.clr   = c;
    o.done  = d;
    return o;
  endfunction

  function automatic int way_of(input logic [NUMWAYS-1:0] oh);
    for (int i = 0; i < NUMWAYS; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Expected output for every cycle after the start edge; cycle k is the k-th
  // entry. Abort is held from cycle abort_at onwards.
  task automatic build(input int abort_at);
    int k;
    k = 1;
    exp_q.delete();
    for (int s = 0; s < NUMLINES; s++) begin
      for (int w = 0; w < NUMWAYS; w++) begin
        exp_q.push_back(mk(1, s, w, 0, 0, 0));
        if (k >= abort_at) begin exp_q.push_back(mk(1, s, w, 0, 0, 1)); return; end
        k++;
        exp_q.push_back(mk(1, s, w, 0, 0, 0));
        if (k >= abort_at) begin exp_q.push_back(mk(1, s, w, 0, 0, 1)); return; end
        k++;
        if (dirty[s][w]) begin
          for (int i = 0; i <= lat[s][w]; i++) begin
            exp_q.push_back(mk(1, s, w, 1, 0, 0));
            k++;
          end
          exp_q.push_back(mk(1, s, w, 0, 1, 0));
          k++;
        end
        exp_q.push_back(mk(1, s, w, 0, 0, 0));
        if (k >= abort_at) begin exp_q.push_back(mk(1, s, w, 0, 0, 1)); return; end
        k++;
      end
    end
    exp_q.push_back(mk(1, NUMLINES - 1, NUMWAYS - 1, 0, 0, 1));
  endtask

  task automatic env_drive(input int k, input int abort_at, input int restart_at);
    int s, w;
    s = int'(FlushSet);
    w = way_of(FlushWay);
    if (ClearDirty && s < NUMLINES) mem[s][w] = 1'b0;
    LineDirty = (s < NUMLINES) ? mem[s][w] : 1'b0;
    if (WBReq) begin
      WBAck = (s < NUMLINES) && (ackcnt >= lat[s][w]);
      ackcnt++;
    end else begin
      WBAck  = 1'b0;
      ackcnt = 0;
    end
    FlushAbort = (k >= abort_at);
    FlushStart = (k == restart_at);
  endtask

  task automatic clear_maps(input int l);
    for (int s = 0; s < NUMLINES; s++)
      for (int w = 0; w < NUMWAYS; w++) begin
        dirty[s][w] = 1'b0;
        lat[s][w]   = l;
      end
  endtask

  task automatic run_flush(input int abort_at, input int restart_at,
                           output int done_cyc, output int wb_cyc, output int clr_cnt);
    obs_t got, want;
    int n;
    for (int s = 0; s < NUMLINES; s++)
      for (int w = 0; w < NUMWAYS; w++) mem[s][w] = dirty[s][w];
    build(abort_at);
    n = exp_q.size();
    done_cyc = 0; wb_cyc = 0; clr_cnt = 0; ackcnt = 0;
    @(negedge clk);
    FlushStart = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got  = {FlushBusy, FlushSet, FlushWay, WBReq, ClearDirty, FlushDone};
      want = exp_q[k-1];
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL trace cycle %0d: got busy=%b set=%0d way=%b wbreq=%b clr=%b done=%b, expected busy=%b set=%0d way=%b wbreq=%b clr=%b done=%b",
                 k, got.busy, got.set, got.way, got.wbreq, got.clr, got.done,
                 want.busy, want.set, want.way, want.wbreq, want.clr, want.done);
      end
      if (FlushDone && done_cyc == 0) done_cyc = k;
      if (WBReq) wb_cyc++;
      if (ClearDirty) clr_cnt++;
      env_drive(k, abort_at, restart_at);
    end
    @(negedge clk);
    chk("idle after done", {FlushBusy, FlushDone, WBReq, ClearDirty}, 0);
    FlushAbort = 1'b0;
    FlushStart = 1'b0;
    WBAck      = 1'b0;
  endtask

  initial begin
    int dc, wb, cl;
    bit seen;
    reset_n = 1'b0; FlushStart = 1'b0; FlushAbort = 1'b0; LineDirty = 1'b0; WBAck = 1'b0;
    #12;
    chk("reset busy", FlushBusy, 0);
    chk("reset set", FlushSet, 0);
    chk("reset way", FlushWay, 1);
    chk("reset wbreq/clr/done", {WBReq, ClearDirty, FlushDone}, 0);
    @(negedge clk); reset_n = 1'b1;

    FlushAbort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort ignored in idle", FlushBusy, 0);
    end
    FlushAbort = 1'b0;

    clear_maps(0);
    run_flush(NOABORT, -1, dc, wb, cl);
    chk("clean done cycle", dc, 1537);
    chk("clean wbreq cycles", wb, 0);
    chk("clean clear count", cl, 0);

    clear_maps(1);
    dirty[5][2] = 1'b1;
    run_flush(NOABORT, -1, dc, wb, cl);
    chk("one dirty done cycle", dc, 1540);
    chk("one dirty wbreq cycles", wb, 2);
    chk("one dirty clear count", cl, 1);

    clear_maps(9);
    dirty[5][2] = 1'b1;
    run_flush(NOABORT, -1, dc, wb, cl);
    chk("slow ack wbreq cycles", wb, 10);
    chk("slow ack done cycle", dc, 1548);

    clear_maps(3);
    dirty[3][1] = 1'b1;
    run_flush(42, -1, dc, wb, cl);
    chk("abort in wb done cycle", dc, 48);
    chk("abort in wb wbreq cycles", wb, 4);
    chk("abort in wb clear count", cl, 1);

    clear_maps(0);
    run_flush(NOABORT, 40 * NUMWAYS * 3 + 5, dc, wb, cl);
    chk("restart ignored done cycle", dc, 1537);

    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NUMLINES; s++)
        for (int w = 0; w < NUMWAYS; w++) begin
          dirty[s][w] = ($urandom_range(15) == 0);
          lat[s][w]   = $urandom_range(3);
        end
      run_flush((r % 2 == 0) ? NOABORT : int'($urandom_range(1700, 1)),
                int'($urandom_range(1500, 2)), dc, wb, cl);
    end

    clear_maps(0);
    dirty[2][1] = 1'b1;
    lat[2][1]   = 1000000;
    for (int s = 0; s < NUMLINES; s++)
      for (int w = 0; w < NUMWAYS; w++) mem[s][w] = dirty[s][w];
    ackcnt = 0;
    @(negedge clk);
    FlushStart = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      if (WBReq) seen = 1'b1;
      env_drive(k, NOABORT, -1);
    end
    chk("wbreq reached before reset", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset wbreq", WBReq, 0);
    chk("async reset busy", FlushBusy, 0);
    chk("async reset clear", ClearDirty, 0);
    chk("async reset set", FlushSet, 0);
    chk("async reset way", FlushWay, 1);
    @(negedge clk);
    reset_n = 1'b1; WBAck = 1'b0; FlushStart = 1'b0;

    for (int s = 0; s < NUMLINES; s++)
      for (int w = 0; w < NUMWAYS; w++) begin
        dirty[s][w] = ($urandom_range(31) == 0);
        lat[s][w]   = $urandom_range(2);
      end
    dirty[0][0] = 1'b1;
    run_flush(NOABORT, -1, dc, wb, cl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_flush_walker.md
Name: cache_flush_walker

Overview:
- Sequential flush engine for the set-associative caches. On a flush request it walks every set and every way and reads each line's dirty bit from the tag/state array.
- Each dirty line is handed to the bus writeback path through a req/ack handshake, and its dirty bit is then cleared.
- It sits beside the replacement logic. LRU picks victims on a miss; this block drives FlushSet/FlushWay and issues writebacks for a full-cache flush (fence.i, cbo, or FlushCache).

Parameters:
- NUMWAYS, 4, associativity; power of 2, ≥1.
- SETLEN, 9, width of the set index.
- NUMLINES, 128, number of sets walked; ≤ 2**SETLEN.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- FlushStart  in  1  request a full flush; sampled only in IDLE.
- FlushAbort  in  1  stop the walk early; honoured outside WRITEBACK/CLEAR.
- LineDirty  in  1  dirty AND valid bit of the line at FlushSet/FlushWay; array read latency is 1 cycle.
- WBAck  in  1  writeback path accepted the line.
- FlushSet  out  SETLEN  set index driven to the array address mux.
- FlushWay  out  NUMWAYS  one-hot way select.
- WBReq  out  1  writeback request for line FlushSet/FlushWay.
- ClearDirty  out  1  one-cycle strobe: clear the dirty bit at FlushSet/FlushWay.
- FlushBusy  out  1  walker active; the cache controller stalls.
- FlushDone  out  1  one-cycle pulse at completion or abort.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE, set counter = 0, way counter = 0.
  - FlushSet = 0, FlushWay = 1 (way 0).
  - WBReq, ClearDirty, FlushBusy, FlushDone all = 0.
- States: IDLE, READ, CHECK, WRITEBACK, CLEAR, ADVANCE, DONE. FlushBusy = 1 in every state except IDLE.
- IDLE:
  - FlushStart = 1 → READ, with counters reset to set 0, way 0.
  - FlushAbort is ignored in IDLE.
- READ: one cycle. FlushSet/FlushWay are presented to the array → CHECK.
- CHECK: sample LineDirty.
  - LineDirty = 1 → WRITEBACK.
  - LineDirty = 0 → ADVANCE.
- WRITEBACK:
  - WBReq = 1, held with FlushSet/FlushWay stable until WBAck is sampled 1.
  - Then → CLEAR.
  - WBAck arriving in the same cycle WBReq first rises is legal: WRITEBACK lasts 1 cycle.
- CLEAR: ClearDirty = 1 for exactly one cycle → ADVANCE.
- ADVANCE:
  - If set = NUMLINES-1 and way = NUMWAYS-1 → DONE.
  - Otherwise increment: way first (way index 0..NUMWAYS-1, inner loop), then set on way wrap (set 0..NUMLINES-1, outer loop). Then → READ.
  - Counters never exceed NUMLINES-1 / NUMWAYS-1.
  - FlushWay is the decoded way counter (always one-hot). FlushSet is the set counter.
- DONE: FlushDone = 1 for one cycle → IDLE. Counters are left as-is until the next start.
- FlushAbort:
  - Sampled in READ, CHECK or ADVANCE → DONE next cycle.
  - Ignored in WRITEBACK and CLEAR, so an in-flight handshake and its dirty clear always complete.
  - An abort still asserted when the walk reaches READ/CHECK/ADVANCE is then honoured.
- FlushStart while busy is ignored; there is no queueing.
- Timing for a clean cache:
  - 3 cycles per line (READ, CHECK, ADVANCE) plus 1 DONE cycle.
  - FlushDone rises 3·NUMWAYS·NUMLINES+1 cycles after the FlushStart sample edge.
- Each dirty line adds 1 + (WBReq→WBAck wait) + 1 cycles.
- Reset mid-operation: async return to reset values in all states, including WRITEBACK. WBReq drops immediately; the writeback path must tolerate a dropped request on reset.
- NUMWAYS = 1: the way counter is a constant 0 and FlushWay = 1.

Test Plan:
- Clean cache, defaults → FlushBusy rises the cycle after start; FlushDone pulses exactly 1537 cycles after the start edge; WBReq and ClearDirty are never asserted; FlushSet sweeps 0..127 with FlushWay cycling 0001→0010→0100→1000 per set.
- Single dirty line at set 5, way 2 → exactly one WBReq with FlushSet = 5 and FlushWay = 0100. With WBAck 1 cycle later, ClearDirty pulses once with the same address. Total time is 1540 cycles.
- Dirty line with WBAck delayed 10 cycles → WBReq is held 10 cycles with the address stable; no ClearDirty before WBAck; the walk then resumes at set 5, way 3.
- FlushAbort during WRITEBACK at set 3, way 1 → the handshake completes, ClearDirty pulses, the next ADVANCE goes to DONE, FlushDone pulses once, then IDLE; set 3, way 2 is never read.
- FlushStart re-pulsed mid-walk at set 40 → no restart; the walk continues to set 127, way 3 and a single FlushDone.
- reset_n asserted low while WBReq = 1 → WBReq, FlushBusy and ClearDirty drop to 0 without a clock edge; FlushSet = 0, FlushWay = 0001. After reset release, a new FlushStart walks from set 0.
